// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and constants for the serial pattern scanner.
package seq_scan_ctrl_pkg;
  localparam int PAT_LEN = 4;
  localparam int FILL_W  = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Fill count stops at PAT_LEN; beyond that only "history is full" matters.
  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_W'(PAT_LEN)) ? f : f + 1'b1;
  endfunction
endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and pattern compare for the scanner.
module seq_match_core
  import seq_scan_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_bit,
  input  logic               i_shift_en,
  input  logic               i_clear,
  input  logic [PAT_LEN-1:0] i_pattern,
  output logic               o_hit
);
  logic [PAT_LEN-1:0] r_hist;
  logic [PAT_LEN-1:0] w_hist_next;
  logic [FILL_W-1:0]  r_fill;
  logic [FILL_W-1:0]  w_fill_next;

  assign w_hist_next = {r_hist[PAT_LEN-2:0], i_bit};
  assign w_fill_next = fill_inc(r_fill);

  // Hit looks at the history including the bit being shifted this cycle.
  assign o_hit = i_shift_en && (w_hist_next == i_pattern) &&
                 (w_fill_next == FILL_W'(PAT_LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift_en) begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// Scans a stream of parallel words, LSB first, for a 4-bit overlapping pattern.
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic [7:0]         num_words,
  input  logic [DATA_W-1:0]  din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e              r_state, w_state_next;
  logic [PAT_LEN-1:0]  r_pattern;
  logic [7:0]          r_words;
  logic [DATA_W-1:0]   r_sreg;
  logic [IDX_W-1:0]    r_idx;
  logic                r_match;
  logic [CNT_W-1:0]    r_cnt;

  logic w_start_ok, w_clear, w_accept, w_shift_en, w_last_bit, w_hit;

  // Abort outranks start in IDLE.
  assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
  assign w_clear    = w_start_ok && (num_words != 8'd0);
  assign w_accept   = (r_state == ST_LOAD) && din_valid && !abort;
  assign w_shift_en = (r_state == ST_SHIFT) && !abort;
  assign w_last_bit = (r_idx == IDX_W'(DATA_W - 1));

  seq_match_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_bit      (r_sreg[0]),
    .i_shift_en (w_shift_en),
    .i_clear    (w_clear),
    .i_pattern  (r_pattern),
    .o_hit      (w_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    din_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok)
          w_state_next = (num_words == 8'd0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (abort)          w_state_next = ST_IDLE;
        else if (din_valid) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (abort)           w_state_next = ST_IDLE;
        else if (w_last_bit) w_state_next = (r_words == 8'd1) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '0;
      r_words   <= '0;
      r_sreg    <= '0;
      r_idx     <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_match <= 1'b0;
      if (w_start_ok) begin
        r_cnt <= '0;
        if (num_words != 8'd0) begin
          r_pattern <= pattern;
          r_words   <= num_words;
        end
      end
      if (w_accept) begin
        r_sreg <= din;
        r_idx  <= '0;
      end
      if (w_shift_en) begin
        r_sreg  <= r_sreg >> 1;
        r_idx   <= r_idx + 1'b1;
        r_match <= w_hit;
        if (w_last_bit)          r_words <= r_words - 8'd1;
        if (w_hit && r_cnt != '1) r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized self-checking bench: a per-job cycle schedule is derived from the bit stream.
module tb_seq_scan_ctrl;
  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst, start, abort, din_valid;
  logic [3:0] pattern;
  logic [7:0] num_words, din;
  logic       din_ready, busy, match, done;
  logic [7:0] match_cnt;

  seq_scan_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .num_words(num_words), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .busy(busy), .match(match),
    .match_cnt(match_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected per-cycle view of a job; index c = cycles after the start edge.
  bit         e_valid [MAXC];
  bit         e_ready [MAXC];
  bit         e_busy  [MAXC];
  bit         e_match [MAXC];
  bit         e_done  [MAXC];
  int         e_cnt   [MAXC];
  logic [7:0] e_din   [MAXC];
  int         n_cyc;
  logic [7:0] j_words [64];
  int         j_gaps  [64];
  int         obs_dones, obs_done_cyc, obs_matches, obs_cnt, last_cnt;

  task automatic build(input logic [3:0] pat, input int nw);
    int c, nb, cnt;
    logic [3:0] h;
    for (int i = 0; i < MAXC; i++) begin
      e_valid[i] = 0; e_ready[i] = 0; e_busy[i] = 0; e_match[i] = 0;
      e_done[i] = 0; e_cnt[i] = 0; e_din[i] = 8'($urandom);
    end
    c = 1; h = 4'd0; nb = 0;
    for (int w = 0; w < nw; w++) begin
      for (int g = 0; g < j_gaps[w]; g++) begin
        e_ready[c] = 1; e_busy[c] = 1; c++;
      end
      e_ready[c] = 1; e_busy[c] = 1; e_valid[c] = 1; e_din[c] = j_words[w]; c++;
      for (int b = 0; b < 8; b++) begin
        e_busy[c]  = 1;
        e_valid[c] = 1'($urandom);
        h  = {h[2:0], j_words[w][b]};
        nb++;
        if (nb >= 4 && h == pat) e_match[c+1] = 1;
        c++;
      end
    end
    e_done[c]  = 1;
    e_valid[c] = 1'($urandom);
    n_cyc = c;
    cnt = 0;
    for (int k = 1; k <= n_cyc + 1; k++) begin
      if (e_match[k]) cnt = (cnt == 255) ? 255 : cnt + 1;
      e_cnt[k] = cnt;
    end
  endtask

  task automatic idle_watch(input int n, input int exp_cnt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(din_ready), 32'd0);
      chk("idle_busy",  32'(busy),      32'd0);
      chk("idle_done",  32'(done),      32'd0);
      chk("idle_match", 32'(match),     32'd0);
      chk("idle_cnt",   32'(match_cnt), 32'(exp_cnt));
      if (done) obs_dones++;
    end
  endtask

  task automatic run_job(input logic [3:0] pat, input int nw, input int abort_at, input int rst_at);
    build(pat, nw);
    obs_dones = 0; obs_done_cyc = 0; obs_matches = 0; obs_cnt = -1;
    start = 1; abort = 0; pattern = pat; num_words = 8'(nw); din_valid = 0;
    @(posedge clk); #1;
    for (int c = 1; c <= n_cyc + 1; c++) begin
      // Start and job parameters churn mid-job; they must be ignored.
      if (c <= n_cyc) begin
        start = 1'($urandom); pattern = 4'($urandom); num_words = 8'($urandom);
      end else start = 0;
      din_valid = e_valid[c];
      din       = e_din[c];
      abort     = (c == abort_at);
      if (c == rst_at) begin
        #1 rst = 0;
        #1;
        chk("rst_ready", 32'(din_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_match", 32'(match),     32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_cnt",   32'(match_cnt), 32'd0);
        start = 0; din_valid = 0;
        @(negedge clk); rst = 1;
        idle_watch(5, 0);
        return;
      end
      @(negedge clk);
      chk("ready", 32'(din_ready), 32'(e_ready[c]));
      chk("busy",  32'(busy),      32'(e_busy[c]));
      chk("match", 32'(match),     32'(e_match[c]));
      chk("done",  32'(done),      32'(e_done[c]));
      chk("cnt",   32'(match_cnt), 32'(e_cnt[c]));
      if (match) obs_matches++;
      if (done) begin
        obs_dones++;
        if (obs_done_cyc == 0) begin obs_done_cyc = c; obs_cnt = 32'(match_cnt); end
      end
      if (c == abort_at) begin
        @(posedge clk); #1;
        abort = 0; start = 0; din_valid = 0;
        idle_watch(5, e_cnt[c]);
        last_cnt = e_cnt[c];
        return;
      end
      @(posedge clk); #1;
    end
    start = 0; din_valid = 0;
    last_cnt = e_cnt[n_cyc];
  endtask

  initial begin
    rst = 0; start = 0; abort = 0; din_valid = 0; pattern = 4'd0; num_words = 8'd0; din = 8'd0;
    last_cnt = 0;
    #12;
    chk("reset_ready", 32'(din_ready), 32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_match", 32'(match),     32'd0);
    chk("reset_done",  32'(done),      32'd0);
    chk("reset_cnt",   32'(match_cnt), 32'd0);
    @(negedge clk); rst = 1;
    @(negedge clk);

    j_words[0] = 8'h2D; j_gaps[0] = 0;
    run_job(4'b1011, 1, 0, 0);
    chk("single_cnt", 32'(obs_cnt), 32'd1);
    chk("single_done_cyc", 32'(obs_done_cyc), 32'd10);
    chk("single_matches", 32'(obs_matches), 32'd1);

    j_words[0] = 8'h55; j_gaps[0] = 0;
    run_job(4'b1010, 1, 0, 0);
    chk("overlap_cnt", 32'(obs_cnt), 32'd3);

    j_words[0] = 8'hFF; j_words[1] = 8'hFF; j_gaps[0] = 0; j_gaps[1] = 3;
    run_job(4'b1111, 2, 0, 0);
    chk("gap_cnt", 32'(obs_cnt), 32'd13);

    for (int w = 0; w < 40; w++) begin j_words[w] = 8'h00; j_gaps[w] = 0; end
    run_job(4'b0000, 40, 0, 0);
    chk("sat_cnt", 32'(obs_cnt), 32'd255);
    chk("sat_dones", 32'(obs_dones), 32'd1);

    run_job(4'b0101, 0, 0, 0);
    chk("zero_done_cyc", 32'(obs_done_cyc), 32'd1);
    chk("zero_cnt", 32'(obs_cnt), 32'd0);

    // Abort together with start in IDLE: nothing may start.
    j_words[0] = 8'hA5; j_gaps[0] = 0;
    run_job(4'b0110, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      start = 1; abort = 1; num_words = (k == 0) ? 8'd3 : 8'd0;
      @(posedge clk); #1; start = 0; abort = 0;
      idle_watch(3, last_cnt);
    end

    for (int j = 0; j < 8; j++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        j_words[w] = 8'($urandom); j_gaps[w] = $urandom_range(0, 3);
      end
      run_job(4'($urandom), nw, 0, 0);
      chk("rand_dones", 32'(obs_dones), 32'd1);
    end

    for (int w = 0; w < 3; w++) begin j_words[w] = 8'($urandom); j_gaps[w] = 0; end
    run_job(4'b1001, 3, 5, 0);
    chk("abort_dones", 32'(obs_dones), 32'd0);

    for (int w = 0; w < 3; w++) begin j_words[w] = 8'hFF; j_gaps[w] = 0; end
    run_job(4'b1111, 3, 0, 6);
    chk("rst_dones", 32'(obs_dones), 32'd0);

    for (int w = 0; w < 2; w++) begin j_words[w] = 8'($urandom); j_gaps[w] = $urandom_range(0, 2); end
    run_job(4'($urandom), 2, 0, 0);
    chk("after_rst_dones", 32'(obs_dones), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the parallel input word width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the match counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous job cancel.
REQ-007 The block SHALL have port pattern, input, 4 bits: target sequence; pattern[3] is the oldest bit and pattern[0] the newest; captured on start.
REQ-008 The block SHALL have port num_words, input, 8 bits: words in the job; captured on start.
REQ-009 The block SHALL have port din, input, DATA_W bits: data word, shifted out LSB first.
REQ-010 The block SHALL have port din_valid, input, 1 bit: din holds a valid word.
REQ-011 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a job is in progress.
REQ-013 The block SHALL have port match, output, 1 bit: registered pulse marking that the last shifted bit completed the pattern.
REQ-014 The block SHALL have port match_cnt, output, CNT_W bits: saturating match count for the current or last job.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-017 In IDLE, on start=1 with num_words!=0, the block SHALL capture pattern and num_words, clear history, fill count and match_cnt, and go to LOAD.
REQ-018 In IDLE, on start=1 with num_words=0, the block SHALL clear match_cnt and go directly to DONE.
REQ-019 The block SHALL drive din_ready=1 only in LOAD, and SHALL accept a word when din_ready and din_valid are both 1; the block SHALL remain in LOAD while din_valid=0.
REQ-020 On word acceptance, the block SHALL load din into the shift register, clear the bit index, and go to SHIFT.
REQ-021 In SHIFT, the block SHALL process one bit per cycle, LSB first, for exactly DATA_W cycles: hist_next = {hist[2:0], bit}, with the fill count saturating at 4.
REQ-022 At each SHIFT edge, the block SHALL set match to 1 when hist_next==pattern and at least 4 bits have been shifted since start; otherwise match SHALL be 0.
REQ-023 In the cycle after a match, match_cnt SHALL have incremented by 1 and SHALL saturate at 2^CNT_W-1.
REQ-024 Detection SHALL be overlapping: history SHALL carry across word boundaries and SHALL NOT be cleared on a match.
REQ-025 After the last bit of a word, the block SHALL decrement the words-remaining count and go to LOAD if it is nonzero, else to DONE.
REQ-026 In DONE, the block SHALL assert done for one cycle and return to IDLE; done SHALL be asserted in no other state.
REQ-027 The block SHALL drive busy=1 in LOAD and SHIFT, and busy=0 in IDLE and DONE.
REQ-028 The block SHALL ignore start in every state except IDLE.
REQ-029 Throughput: with din_valid held at 1, each word SHALL take DATA_W+1 cycles; done SHALL be high in cycle 9N+1 after the start edge for N words with DATA_W=8.
REQ-030 On abort=1 in LOAD or SHIFT, the block SHALL go to IDLE at the next edge without a done pulse, with match=0 and match_cnt held.
REQ-031 If abort and start are both 1 in IDLE, abort SHALL take priority and start SHALL be ignored.
REQ-032 match_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-033 While rst=0, the block SHALL immediately force state=IDLE, din_ready=0, busy=0, match=0, done=0, match_cnt=0, and clear history, fill count, bit index and words-remaining count.
REQ-034 Reset asserted mid-job SHALL discard the job with no done pulse; after release, the block SHALL wait in IDLE for start.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (2 bits) and the pattern length constant (4).
REQ-036 The 4-bit history register, fill counter and compare SHALL be one sub-module, seq_match_core (inputs bit, shift_en, clear, pattern; output hit), instantiated once.

Verification
REQ-037 pattern=1011, num_words=1, din=0x2D -> exactly one match pulse (after bit 3), match_cnt=1, done at cycle 10.
REQ-038 pattern=1010, din=0x55 -> matches after bits 3, 5 and 7, match_cnt=3 (overlap check).
REQ-039 pattern=1111, num_words=2, din=0xFF,0xFF, din_valid gapped for 3 cycles between words -> match_cnt=13, din_ready held during the gap.
REQ-040 pattern=0000, num_words=40, all din=0x00 -> match_cnt saturates at 255, done pulses once.
REQ-041 num_words=0 -> done in the cycle after start, match_cnt=0, din_ready never 1.
REQ-042 abort in the 4th SHIFT cycle, then rst pulsed low in a second job -> no done pulse in either job; all outputs zero after reset; a third job runs normally.
